// File: rtl/scan_display.sv
// scan_display: multiplexed 7-segment scan driver for the elevator front panel.
// Time-multiplexes up to 16 common-anode digits. Each digit slot lasts
// SCAN_DIV clocks. The first BLANK_CYC clocks of a slot keep all anodes off to
// prevent ghosting. A digit's mode, data, blink and dp inputs are snapshotted
// when its slot starts, so input changes during a slot have no effect on it.
// Ports:
//   clk         - system clock
//   rst_n       - synchronous active-low reset
//   enable      - 0 darkens the panel (counters keep running)
//   digit_mode  - 2 bits per digit: 0 blank, 1 hex, 2 raw, 3 call pattern
//   digit_data  - 8 bits per digit
//   blink_mask  - per-digit blink enable
//   dp_mask     - per-digit decimal point (modes 1..3)
//   seg         - active-low segments, seg[0]=a .. seg[6]=g, seg[7]=dp
//   an          - active-low anodes, at most one low
//   frame_tick  - one-cycle pulse at the start of each scan frame
module scan_display #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 16,
    parameter int BLINK_DIV  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [2*NUM_DIGITS-1:0] digit_mode,
    input  logic [8*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

    localparam logic [1:0] MODE_BLANK = 2'd0;
    localparam logic [1:0] MODE_HEX   = 2'd1;
    localparam logic [1:0] MODE_RAW   = 2'd2;
    localparam logic [1:0] MODE_CALL  = 2'd3;

    // Hex digit to active-low a..g segments (dp bit left off).
    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        logic [7:0] r;
        case (v)
            4'h0: r = 8'hC0;
            4'h1: r = 8'hF9;
            4'h2: r = 8'hA4;
            4'h3: r = 8'hB0;
            4'h4: r = 8'h99;
            4'h5: r = 8'h92;
            4'h6: r = 8'h82;
            4'h7: r = 8'hF8;
            4'h8: r = 8'h80;
            4'h9: r = 8'h90;
            4'hA: r = 8'h88;
            4'hB: r = 8'h83;
            4'hC: r = 8'hC6;
            4'hD: r = 8'hA1;
            4'hE: r = 8'h86;
            4'hF: r = 8'h8E;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    // Full segment pattern for one digit, including the decimal point.
    function automatic logic [7:0] seg_encode(input logic [1:0] mode,
                                              input logic [7:0] d,
                                              input logic       dp);
        logic [7:0] r;
        case (mode)
            MODE_HEX:  r = hex_seg(d[3:0]);
            MODE_RAW:  r = {1'b1, ~d[6:0]};
            // Call indicator: lower floor uses c/b, upper floor uses e/f.
            MODE_CALL: r = {2'b11, ~d[3], ~d[2], 1'b1, ~d[0], ~d[1], 1'b1};
            default:   r = 8'hFF;
        endcase
        if (mode != MODE_BLANK) begin
            r[7] = ~dp;
        end else begin
            r[7] = 1'b1;
        end
        return r;
    endfunction

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [1:0]            snap_mode_q, snap_mode_d;
    logic [7:0]            snap_data_q, snap_data_d;
    logic                  snap_blink_q, snap_blink_d;
    logic                  snap_dp_q, snap_dp_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    logic [1:0] mode_arr_s [NUM_DIGITS];
    logic [7:0] data_arr_s [NUM_DIGITS];

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_slice
            assign mode_arr_s[g] = digit_mode[2*g +: 2];
            assign data_arr_s[g] = digit_data[8*g +: 8];
        end
    endgenerate

    logic                  cnt_wrap_s, idx_wrap_s, slot_start_s, lit_s;
    logic [1:0]            eff_mode_s;
    logic [7:0]            eff_data_s;
    logic                  eff_blink_s, eff_dp_s;
    logic [NUM_DIGITS-1:0] onehot_s;

    // Next-state for counters, snapshot and registered outputs.
    always_comb begin
        cnt_wrap_s   = (cnt_q == CNT_LAST);
        idx_wrap_s   = (idx_q == IDX_LAST);
        slot_start_s = (cnt_q == {CNT_W{1'b0}});

        cnt_d         = cnt_wrap_s ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (cnt_wrap_s) begin
            idx_d = idx_wrap_s ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
            if (idx_wrap_s) begin
                if (blink_cnt_q == BLK_LAST) begin
                    blink_cnt_d   = {BLK_W{1'b0}};
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLK_W'(1);
                end
            end else begin
                blink_cnt_d = blink_cnt_q;
            end
        end else begin
            idx_d = idx_q;
        end

        // In the capture cycle the output path sees the value being captured,
        // so the slot never shows the previous digit's snapshot.
        if (slot_start_s) begin
            eff_mode_s  = mode_arr_s[idx_q];
            eff_data_s  = data_arr_s[idx_q];
            eff_blink_s = blink_mask[idx_q];
            eff_dp_s    = dp_mask[idx_q];
        end else begin
            eff_mode_s  = snap_mode_q;
            eff_data_s  = snap_data_q;
            eff_blink_s = snap_blink_q;
            eff_dp_s    = snap_dp_q;
        end
        snap_mode_d  = eff_mode_s;
        snap_data_d  = eff_data_s;
        snap_blink_d = eff_blink_s;
        snap_dp_d    = eff_dp_s;

        lit_s = enable && (cnt_q >= CNT_BLANK) && (eff_mode_s != MODE_BLANK)
                && !(blink_phase_q && eff_blink_s);
        onehot_s = NUM_DIGITS'(1) << idx_q;

        if (lit_s) begin
            an_d  = ~onehot_s;
            seg_d = seg_encode(eff_mode_s, eff_data_s, eff_dp_s);
        end else begin
            an_d  = {NUM_DIGITS{1'b1}};
            seg_d = 8'hFF;
        end
        frame_tick_d = slot_start_s && (idx_q == {IDX_W{1'b0}});
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= {CNT_W{1'b0}};
            idx_q         <= {IDX_W{1'b0}};
            blink_cnt_q   <= {BLK_W{1'b0}};
            blink_phase_q <= 1'b0;
            snap_mode_q   <= MODE_BLANK;
            snap_data_q   <= 8'h00;
            snap_blink_q  <= 1'b0;
            snap_dp_q     <= 1'b0;
            seg_q         <= 8'hFF;
            an_q          <= {NUM_DIGITS{1'b1}};
            frame_tick_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            snap_mode_q   <= snap_mode_d;
            snap_data_q   <= snap_data_d;
            snap_blink_q  <= snap_blink_d;
            snap_dp_q     <= snap_dp_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_scan_display.sv
// Testbench for scan_display: a 4-digit instance (SCAN_DIV=4, BLANK_CYC=1,
// BLINK_DIV=2) driven from a vector table plus hand-written sequences, and a
// 1-digit instance for the upper hex range.
module tb_scan_display;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  digit_mode;
    logic [31:0] digit_data;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    logic        en1;
    logic [1:0]  mode1;
    logic [7:0]  data1;
    logic        blink1;
    logic        dp1;
    logic [7:0]  seg1;
    logic        an1;
    logic        ft1;

    int errors = 0;
    int checks = 0;

    scan_display #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digit_mode(digit_mode),
        .digit_data(digit_data), .blink_mask(blink_mask), .dp_mask(dp_mask),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    scan_display #(.NUM_DIGITS(1), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_DIV(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .digit_mode(mode1),
        .digit_data(data1), .blink_mask(blink1), .dp_mask(dp1),
        .seg(seg1), .an(an1), .frame_tick(ft1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mode;
        logic [31:0] data;
        logic [3:0]  dp;
        logic [3:0]  lit;
        logic [31:0] segs;
    } vec_t;

    vec_t vecs [5];

    // Expected-state for the model: which digits light, their patterns, blink.
    logic [3:0]  lit_m;
    logic [3:0]  blk_m;
    logic [31:0] segs_m;

    logic [7:0] hexhi [6] = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d actual=%h expected=%h", name, k, act, exp);
        end
    endtask

    // Expected outputs k cycles after reset release (4 digits, 4-cycle slots).
    function automatic void model(input int k, input bit en, output logic [3:0] ean,
                                  output logic [7:0] eseg, output logic eft);
        int slot;
        int c;
        bit phase;
        bit lit;
        slot  = (k / 4) % 4;
        c     = k % 4;
        phase = (((k / 16) / 2) % 2) == 1;
        lit   = en && (c >= 1) && lit_m[slot] && !(phase && blk_m[slot]);
        ean   = lit ? ~(4'b0001 << slot) : 4'hF;
        eseg  = lit ? segs_m[8*slot +: 8] : 8'hFF;
        eft   = (k % 16) == 0;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_an", -1, {4'h0, an}, 8'h0F);
        chk("rst_seg", -1, seg, 8'hFF);
        chk("rst_ft", -1, {7'd0, frame_tick}, 8'h00);
        chk("rst_an1", -1, {7'd0, an1}, 8'h01);
        chk("rst_seg1", -1, seg1, 8'hFF);
        chk("rst_ft1", -1, {7'd0, ft1}, 8'h00);
        rst_n = 1'b1;
    endtask

    // Run n cycles from reset release; enable is low for cycles [off_from, off_to).
    task automatic run_model(input int n, input int off_from, input int off_to);
        logic [3:0] ean;
        logic [7:0] eseg;
        logic       eft;
        for (int k = 0; k < n; k++) begin
            if (k == off_from) enable = 1'b0;
            if (k == off_to) enable = 1'b1;
            @(posedge clk);
            #1;
            model(k, !(k >= off_from && k < off_to), ean, eseg, eft);
            chk("an", k, {4'h0, an}, {4'h0, ean});
            chk("seg", k, seg, eseg);
            chk("frame_tick", k, {7'd0, frame_tick}, {7'd0, eft});
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        digit_mode = 8'h00;
        digit_data = 32'h0;
        blink_mask = 4'h0;
        dp_mask    = 4'h0;
        en1        = 1'b1;
        mode1      = 2'd1;
        data1      = 8'h0A;
        blink1     = 1'b0;
        dp1        = 1'b0;

        //           mode    data           dp       lit      segs (digit3..digit0)
        vecs[0] = '{8'h55, 32'h03020100, 4'b0000, 4'b1111, 32'hB0A4F9C0};
        vecs[1] = '{8'h75, 32'h070A0504, 4'b0000, 4'b1111, 32'hF8DD9299};
        vecs[2] = '{8'h72, 32'hF805127F, 4'b1000, 4'b1101, 32'h00EBFF80};
        vecs[3] = '{8'h55, 32'h0C0B0A09, 4'b0010, 4'b1111, 32'hC6830890};
        vecs[4] = '{8'hFA, 32'h0FF0003F, 4'b1001, 4'b1111, 32'h49FFFF40};

        repeat (2) @(posedge clk);
        #1;

        // Table-driven: two full frames per vector after a fresh reset.
        for (int i = 0; i < 5; i++) begin
            digit_mode = vecs[i].mode;
            digit_data = vecs[i].data;
            dp_mask    = vecs[i].dp;
            blink_mask = 4'h0;
            lit_m      = vecs[i].lit;
            blk_m      = 4'h0;
            segs_m     = vecs[i].segs;
            do_reset();
            run_model(32, -1, -1);
        end

        // Mid-slot data change on digit 0 (5 -> 8 at cnt==2) with dp lit.
        digit_mode = 8'h01;
        digit_data = 32'h00000005;
        dp_mask    = 4'b0001;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            logic [3:0] ean;
            logic [7:0] eseg;
            bool_blk : begin
                bit on;
                if (k == 2) digit_data[7:0] = 8'h08;
                @(posedge clk);
                #1;
                on   = ((k / 4) % 4 == 0) && (k % 4 >= 1);
                ean  = on ? 4'hE : 4'hF;
                eseg = on ? ((k < 16) ? 8'h12 : 8'h00) : 8'hFF;
                chk("midslot_an", k, {4'h0, an}, {4'h0, ean});
                chk("midslot_seg", k, seg, eseg);
            end
        end

        // Blink on digit 0, digit 1 blank; reset at idx=2,cnt=3 during a dark frame.
        digit_mode = 8'h51;
        digit_data = 32'h03027700;
        dp_mask    = 4'h0;
        blink_mask = 4'b0001;
        lit_m      = 4'b1101;
        blk_m      = 4'b0001;
        segs_m     = 32'hB0A4FFC0;
        do_reset();
        run_model(43, -1, -1);
        do_reset();
        run_model(80, -1, -1);

        // Enable dropped mid-slot, restored later; frame_tick keeps its spacing.
        digit_mode = vecs[0].mode;
        digit_data = vecs[0].data;
        dp_mask    = 4'h0;
        blink_mask = 4'h0;
        lit_m      = vecs[0].lit;
        blk_m      = 4'h0;
        segs_m     = vecs[0].segs;
        do_reset();
        run_model(48, 21, 41);

        // Single-digit instance: hex A..F, frame_tick every slot.
        data1 = 8'h0A;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            if (k % 4 == 0) data1 = 8'(8'h0A + k / 4);
            @(posedge clk);
            #1;
            chk("hex1_an", k, {7'd0, an1}, (k % 4 >= 1) ? 8'h00 : 8'h01);
            chk("hex1_seg", k, seg1, (k % 4 >= 1) ? hexhi[k / 4] : 8'hFF);
            chk("hex1_ft", k, {7'd0, ft1}, (k % 4 == 0) ? 8'h01 : 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_display.md
# scan_display

Parametrised multiplexed 7-segment scan driver for the elevator front panel. It time-multiplexes up to 16 common-anode digits from one clock. Each digit has its own display mode: blank, hex numeric, raw segments, or the two-floor up/down call-indicator pattern. It adds per-digit blink, decimal-point control, anode dead-time against ghosting, and per-slot input snapshotting. It sits between the elevator controller (floor, countdown, and call-button vectors packed by the top level) and the board seg/an pins.

## Interface
Parameters:
- NUM_DIGITS, default 8: number of digits scanned, legal range 1..16.
- SCAN_DIV, default 100000: clocks per digit slot; must be greater than BLANK_CYC.
- BLANK_CYC, default 16: dead-time clocks at the start of each slot, during which all anodes are off.
- BLINK_DIV, default 64: scan frames per blink half-period; must be at least 1.

Ports:
- clk, input, 1: system clock. This is the only clock.
- rst_n, input, 1: synchronous, active-low reset.
- enable, input, 1: 0 forces the whole panel dark; the counters keep running.
- digit_mode, input, 2*NUM_DIGITS: mode for digit i in bits [2i+1:2i]. 0 = blank, 1 = hex, 2 = raw, 3 = call.
- digit_data, input, 8*NUM_DIGITS: data for digit i in bits [8i+7:8i].
- blink_mask, input, NUM_DIGITS: 1 = the digit blinks.
- dp_mask, input, NUM_DIGITS: 1 = the decimal point is lit (modes 1–3 only).
- seg, output, 8: active-low segment lines. seg[0] = a through seg[6] = g, seg[7] = dp.
- an, output, NUM_DIGITS: active-low anodes, at most one low at a time.
- frame_tick, output, 1: one-cycle pulse at the start of each scan frame.

## Operation
- Prescaler cnt runs 0..SCAN_DIV-1, then wraps to 0. Digit index idx advances when cnt wraps, going from NUM_DIGITS-1 back to 0.
- Snapshot: when cnt==0, the slice of digit_mode, digit_data, blink_mask and dp_mask for the incoming idx is captured into holding registers.
  - The displayed digit uses only these registers for the rest of the slot, so input changes mid-slot are ignored.
- Segment encoding is active-low and derived from the snapshot d:
  - Mode 0: seg = 8'hFF.
  - Mode 1 (hex, uses d[3:0]):
    - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8.
    - 8 = 80, 9 = 90, A = 88, b = 83, C = C6, d = A1, E = 86, F = 8E.
    - d[7:4] is ignored.
  - Mode 2 (raw): seg[6:0] = ~d[6:0]; d[7] is ignored.
  - Mode 3 (call): d[0] = lower-floor down lights c (seg[2]); d[1] = lower-floor up lights b (seg[1]); d[2] = upper-floor down lights e (seg[4]); d[3] = upper-floor up lights f (seg[5]). All other segments are off.
  - Modes 1–3: seg[7] = ~dp.
- Blink:
  - blink_cnt counts frames 0..BLINK_DIV-1. At the frame boundary where it wraps, blink_phase toggles.
  - While blink_phase==1, any digit whose snapshot blink bit is 1 shows an all high and seg = FF for the whole slot.
- Anode: an[idx] is low only when enable==1, cnt>=BLANK_CYC, and the digit is not blanked by mode 0 or by blink. Otherwise an is all ones.
  - When an is all ones, seg is driven FF.
- enable==0: an and seg are all ones; cnt, idx and blink state keep advancing.
- Reset (rst_n low at a clock edge), applied even mid-slot or mid-blink:
  - cnt = 0, idx = 0, blink_cnt = 0, blink_phase = 0.
  - Snapshot registers cleared to mode 0.
  - Outputs: an all ones, seg = 8'hFF, frame_tick = 0.
  - Scanning restarts at digit 0.

## Timing
- All outputs are registered: an, seg and frame_tick at cycle t reflect cnt, idx, snapshot and enable as they stood at cycle t-1.
- In the first cycle after rst_n goes high, cnt = 0 and idx = 0, and the digit-0 snapshot is taken. an[0] first goes low 1+BLANK_CYC cycles after reset release.
- Slot length is exactly SCAN_DIV cycles. The anode is low for SCAN_DIV-BLANK_CYC of them and high for the first BLANK_CYC.
- frame_tick is high for one cycle, one cycle after the cycle in which cnt==0 and idx==0. There is one pulse every NUM_DIGITS*SCAN_DIV cycles.
- A change to an input takes effect at the next slot boundary for that digit, except enable, which has a latency of 1 cycle.
- Blink period: blink_phase toggles every BLINK_DIV*NUM_DIGITS*SCAN_DIV cycles.
- Counter widths use $clog2 of their ranges. NUM_DIGITS=1 is legal: idx stays 0 and frame_tick pulses every slot.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=2 unless noted.
1. Reset then scan:
   - Stimulus: all digits mode 1 with data 0,1,2,3; enable=1.
   - Required: an sequence E,E,E per slot (each preceded by one F cycle) cycling 1110 → 1101 → 1011 → 0111. seg values C0, F9, A4, B0 in step with the anodes. frame_tick every 16 cycles.
2. Call pattern:
   - Stimulus: digit 2 mode 3, data 4'b1010.
   - Required: seg = 8'b1101_1101 (b and f lit) while an = 1011. Data 4'b0101 gives seg = 8'b1110_1011.
3. Mid-slot change plus dp:
   - Stimulus: change digit_data[3:0] of the active digit from 5 to 8 at cnt==2; dp_mask bit set.
   - Required: seg stays 8'h12 until the slot ends; 8'h00 is shown on that digit's next visit.
4. Blink and blank:
   - Stimulus: blink_mask = 4'b0001; digit 1 in mode 0.
   - Required: digit 0 is dark for 2 frames, lit for 2 frames, repeating. an[1] never goes low. Other digits are unaffected.
5. enable and reset mid-operation:
   - Stimulus: drop enable at an arbitrary cycle.
   - Required: on the next cycle an = F and seg = FF, and frame_tick spacing is unchanged.
   - Stimulus: assert rst_n=0 for 1 cycle at idx=2, cnt=3.
   - Required: an = F, seg = FF, frame_tick = 0 on the following cycle. Scanning restarts at digit 0 with blink_phase = 0.
6. Hex upper range:
   - Stimulus: data A..F on digit 0, with NUM_DIGITS=1.
   - Required: seg values 88, 83, C6, A1, 86, 8E. frame_tick pulses every 4 cycles.
